// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_FWAIT, S_DECODE,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MADDR, S_LRD, S_LWAIT, S_LWB,
    S_SWR, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_ILL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_unit_if.sv
// Control/datapath boundary: IR fields and zero flag in, strobes and selects out.
interface ctrl_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_wr;
  logic       ir_wr;
  logic       a_wr;
  logic       b_wr;
  logic       alu_out_wr;
  logic       reg_wr;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       illegal;

  // Datapath side.
  modport master (
    output opcode, funct, zero,
    input  pc_write, pc_src, iord, mem_wr, ir_wr, a_wr, b_wr, alu_out_wr,
           reg_wr, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal
  );

  // Control side.
  modport slave (
    input  opcode, funct, zero,
    output pc_write, pc_src, iord, mem_wr, ir_wr, a_wr, b_wr, alu_out_wr,
           reg_wr, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Instruction classifier: opcode/funct to class, R-type ALU op, and legality.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic [2:0]   r_alu_op,
  output logic         illegal
);

  // Classify the instruction; unsupported opcodes and R-type functs are illegal.
  always_comb begin
    cls      = CLS_ILL;
    r_alu_op = ALU_ADD;
    illegal  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        cls = CLS_R;
        unique case (funct)
          FN_ADD:  r_alu_op = ALU_ADD;
          FN_SUB:  r_alu_op = ALU_SUB;
          FN_AND:  r_alu_op = ALU_AND;
          FN_XOR:  r_alu_op = ALU_XOR;
          default: begin
            cls     = CLS_ILL;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_J:    cls = CLS_J;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Multicycle MIPS-subset control FSM; all strobes are decoded from state.
module ctrl_unit
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  ctrl_unit_if.slave  bus
);

  state_t       state, state_nxt;
  instr_class_t cls;
  logic [2:0]   r_alu_op;
  logic         dec_illegal;

  ctrl_decode u_decode (
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .cls      (cls),
    .r_alu_op (r_alu_op),
    .illegal  (dec_illegal)
  );

  // State register; reset forces RST, which decodes every output to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RST;
    else          state <= state_nxt;
  end

  // Next-state sequencing.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_FWAIT;
      S_FWAIT:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) state_nxt = S_ILLEGAL;
        else begin
          unique case (cls)
            CLS_R:           state_nxt = S_EXEC_R;
            CLS_ADDI:        state_nxt = S_EXEC_I;
            CLS_LW, CLS_SW:  state_nxt = S_MADDR;
            CLS_BEQ, CLS_BNE: state_nxt = S_BRANCH;
            CLS_J:           state_nxt = S_JUMP;
            default:         state_nxt = S_ILLEGAL;
          endcase
        end
      end
      S_EXEC_R:  state_nxt = S_WB_R;
      S_WB_R:    state_nxt = S_FETCH;
      S_EXEC_I:  state_nxt = S_WB_I;
      S_WB_I:    state_nxt = S_FETCH;
      S_MADDR:   state_nxt = (cls == CLS_LW) ? S_LRD : S_SWR;
      S_LRD:     state_nxt = S_LWAIT;
      S_LWAIT:   state_nxt = S_LWB;
      S_LWB:     state_nxt = S_FETCH;
      S_SWR:     state_nxt = S_FETCH;
      S_BRANCH:  state_nxt = S_FETCH;
      S_JUMP:    state_nxt = S_FETCH;
      S_ILLEGAL: state_nxt = S_ILLEGAL;
      default:   state_nxt = S_RST;
    endcase
  end

  // Moore output decode; only BRANCH's pc_write also looks at zero.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_src     = PCSRC_ALU;
    bus.iord       = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ir_wr      = 1'b0;
    bus.a_wr       = 1'b0;
    bus.b_wr       = 1'b0;
    bus.alu_out_wr = 1'b0;
    bus.reg_wr     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_B;
    bus.alu_op     = '0;
    bus.illegal    = 1'b0;
    unique case (state)
      S_FETCH: begin
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_op    = ALU_ADD;
        bus.pc_src    = PCSRC_ALU;
        bus.pc_write  = 1'b1;
      end
      S_FWAIT: bus.ir_wr = 1'b1;
      S_DECODE: begin
        bus.a_wr       = 1'b1;
        bus.b_wr       = 1'b1;
        bus.alu_src_b  = SRCB_IMM_SH2;
        bus.alu_op     = ALU_ADD;
        bus.alu_out_wr = 1'b1;
      end
      S_EXEC_R: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = SRCB_B;
        bus.alu_op     = r_alu_op;
        bus.alu_out_wr = 1'b1;
      end
      S_WB_R: begin
        bus.reg_wr  = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_EXEC_I, S_MADDR: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = SRCB_IMM;
        bus.alu_op     = ALU_ADD;
        bus.alu_out_wr = 1'b1;
      end
      S_WB_I: bus.reg_wr = 1'b1;
      S_LRD:  bus.iord = 1'b1;
      S_LWB: begin
        bus.reg_wr     = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_SWR: begin
        bus.iord   = 1'b1;
        bus.mem_wr = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_B;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = PCSRC_ALUOUT;
        bus.pc_write  = (cls == CLS_BNE) ? !bus.zero : bus.zero;
      end
      S_JUMP: begin
        bus.pc_src   = PCSRC_JUMP;
        bus.pc_write = 1'b1;
      end
      S_ILLEGAL: bus.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
